// File: rtl/npu_ctrl_pkg.sv
// Shared types and constants for the NPU sequencer: FSM states, register
// offsets, control/status bit positions and systolic op encodings.
package npu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    OS_FLOW1  = 3'd1,
    OS_FLOW2  = 3'd2,
    OS_DRAIN  = 3'd3,
    OS_STORE  = 3'd4,
    OS_END    = 3'd5,
    INTRA_RUN = 3'd6,
    INTRA_END = 3'd7
  } seq_state_e;

  // Byte offsets from the register map base
  localparam logic [5:0] OFF_CTRL    = 6'h00;
  localparam logic [5:0] OFF_STAT    = 6'h04;
  localparam logic [5:0] OFF_A_BASE  = 6'h08;
  localparam logic [5:0] OFF_M       = 6'h0C;
  localparam logic [5:0] OFF_W_BASE  = 6'h10;
  localparam logic [5:0] OFF_N       = 6'h14;
  localparam logic [5:0] OFF_K       = 6'h18;
  localparam logic [5:0] OFF_O_BASE  = 6'h1C;
  localparam logic [5:0] OFF_INTRA_O = 6'h20;
  localparam logic [5:0] OFF_INTRA_A = 6'h24;

  // CTRL / STAT bit positions
  localparam int CTRL_START_OS    = 0;
  localparam int CTRL_START_INTRA = 1;
  localparam int CTRL_ABORT       = 2;
  localparam int CTRL_IRQ_EN      = 3;
  localparam int STAT_BUSY        = 0;
  localparam int STAT_DONE        = 1;
  localparam int STAT_ERR         = 2;

  // Systolic op encodings
  localparam logic [2:0] OP_IDLE  = 3'b000;
  localparam logic [2:0] OP_FLOW  = 3'b100;
  localparam logic [2:0] OP_DRAIN = 3'b110;

  // Layer parameter registers: the ones frozen while a sequence runs
  function automatic logic is_param_off(input logic [5:0] off);
    return off inside {OFF_A_BASE, OFF_M, OFF_W_BASE, OFF_N, OFF_K,
                       OFF_O_BASE, OFF_INTRA_O, OFF_INTRA_A};
  endfunction

endpackage

// File: rtl/npu_ctrl_regfile.sv
// Bus-facing register file: address decode, parameter storage with clamping,
// start/abort qualification, STAT done/err bookkeeping and registered reads.
module npu_ctrl_regfile
  import npu_ctrl_pkg::*;
#(
  parameter int                    DWidth     = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    ARRAY_M    = 16,
  parameter int                    ARRAY_N    = 16,
  parameter int                    K_MAX      = 256,
  parameter logic [ADDR_WIDTH-1:0] PARA_BASE  = '0,
  localparam int MW = $clog2(ARRAY_M) + 1,
  localparam int NW = $clog2(ARRAY_N) + 1,
  localparam int KW = $clog2(K_MAX) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cen_i,
  input  logic                  wen_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DWidth-1:0]     wdata_i,
  output logic [DWidth-1:0]     rdata_o,
  input  logic                  busy_i,
  input  logic                  set_done_i,
  output logic                  os_go_o,
  output logic                  intra_go_o,
  output logic                  abort_o,
  output logic                  irq_en_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] a_base_o,
  output logic [ADDR_WIDTH-1:0] w_base_o,
  output logic [ADDR_WIDTH-1:0] o_base_o,
  output logic [ADDR_WIDTH-1:0] intra_o_base_o,
  output logic [ADDR_WIDTH-1:0] intra_a_base_o,
  output logic [MW-1:0]         m_o,
  output logic [NW-1:0]         n_o,
  output logic [KW-1:0]         k_o
);

  logic [ADDR_WIDTH-1:0] off_full;
  logic [5:0]            off;
  logic                  hit, wr, ctrl_wr, stat_wr;
  logic                  s_os, s_in, ab;
  logic                  start_err, param_err, abort_err;
  logic                  irq_en_q, done_q, err_q;
  logic [ADDR_WIDTH-1:0] a_base_q, w_base_q, o_base_q, io_base_q, ia_base_q;
  logic [MW-1:0]         m_q, m_wr;
  logic [NW-1:0]         n_q, n_wr;
  logic [KW-1:0]         k_q, k_wr;
  logic [DWidth-1:0]     rd_val, rdata_q;

  // Decode: in-window, word-aligned offsets only
  assign off_full = addr_i - PARA_BASE;
  assign off      = off_full[5:0];
  assign hit      = (off_full[ADDR_WIDTH-1:6] == '0) && (off_full[1:0] == 2'b00);
  assign wr       = cen_i && wen_i && hit;
  assign ctrl_wr  = wr && (off == OFF_CTRL);
  assign stat_wr  = wr && (off == OFF_STAT);

  // Sizes saturate to the physical array / reduction limits
  assign m_wr = (wdata_i > DWidth'(ARRAY_M)) ? MW'(ARRAY_M) : MW'(wdata_i);
  assign n_wr = (wdata_i > DWidth'(ARRAY_N)) ? NW'(ARRAY_N) : NW'(wdata_i);
  assign k_wr = (wdata_i > DWidth'(K_MAX))   ? KW'(K_MAX)   : KW'(wdata_i);

  // Start/abort qualification; a rejected start never reaches the FSM
  assign s_os       = ctrl_wr && wdata_i[CTRL_START_OS];
  assign s_in       = ctrl_wr && wdata_i[CTRL_START_INTRA];
  assign ab         = ctrl_wr && wdata_i[CTRL_ABORT];
  assign os_go_o    = s_os && !s_in && !busy_i &&
                      (m_q != '0) && (n_q != '0) && (k_q != '0);
  assign intra_go_o = s_in && !s_os && !busy_i && (m_q != '0);
  assign abort_o    = ab;
  assign start_err  = (s_os || s_in) && !(os_go_o || intra_go_o);
  assign param_err  = wr && busy_i && is_param_off(off);
  assign abort_err  = ab && busy_i;

  // Layer parameter storage; writes while busy are dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_base_q  <= '0;
      w_base_q  <= '0;
      o_base_q  <= '0;
      io_base_q <= '0;
      ia_base_q <= '0;
      m_q       <= '0;
      n_q       <= '0;
      k_q       <= '0;
    end else if (wr && !busy_i) begin
      case (off)
        OFF_A_BASE:  a_base_q  <= ADDR_WIDTH'(wdata_i);
        OFF_M:       m_q       <= m_wr;
        OFF_W_BASE:  w_base_q  <= ADDR_WIDTH'(wdata_i);
        OFF_N:       n_q       <= n_wr;
        OFF_K:       k_q       <= k_wr;
        OFF_O_BASE:  o_base_q  <= ADDR_WIDTH'(wdata_i);
        OFF_INTRA_O: io_base_q <= ADDR_WIDTH'(wdata_i);
        OFF_INTRA_A: ia_base_q <= ADDR_WIDTH'(wdata_i);
        default: ;
      endcase
    end
  end

  // irq_en, done and err; a set event beats a same-cycle W1C
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= wdata_i[CTRL_IRQ_EN];
      if (set_done_i)
        done_q <= 1'b1;
      else if (os_go_o || intra_go_o || abort_err || (stat_wr && wdata_i[STAT_DONE]))
        done_q <= 1'b0;
      if (start_err || param_err || abort_err)
        err_q <= 1'b1;
      else if (stat_wr && wdata_i[STAT_ERR])
        err_q <= 1'b0;
    end
  end

  // Read mux over pre-update register values
  always_comb begin
    rd_val = '0;
    case (off)
      OFF_CTRL:    rd_val[CTRL_IRQ_EN] = irq_en_q;
      OFF_STAT: begin
        rd_val[STAT_BUSY] = busy_i;
        rd_val[STAT_DONE] = done_q;
        rd_val[STAT_ERR]  = err_q;
      end
      OFF_A_BASE:  rd_val = DWidth'(a_base_q);
      OFF_M:       rd_val = DWidth'(m_q);
      OFF_W_BASE:  rd_val = DWidth'(w_base_q);
      OFF_N:       rd_val = DWidth'(n_q);
      OFF_K:       rd_val = DWidth'(k_q);
      OFF_O_BASE:  rd_val = DWidth'(o_base_q);
      OFF_INTRA_O: rd_val = DWidth'(io_base_q);
      OFF_INTRA_A: rd_val = DWidth'(ia_base_q);
      default: ;
    endcase
    if (!hit) rd_val = '0;
  end

  // One-cycle read latency; data held until the next read
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              rdata_q <= '0;
    else if (cen_i && !wen_i) rdata_q <= rd_val;
  end

  assign rdata_o        = rdata_q;
  assign irq_en_o       = irq_en_q;
  assign done_o         = done_q;
  assign a_base_o       = a_base_q;
  assign w_base_o       = w_base_q;
  assign o_base_o       = o_base_q;
  assign intra_o_base_o = io_base_q;
  assign intra_a_base_o = ia_base_q;
  assign m_o            = m_q;
  assign n_o            = n_q;
  assign k_o            = k_q;

endmodule

// File: rtl/npu_seq_ctrl.sv
// NPU sequencer top: register file plus the OS-matmul / intranet-copy FSM,
// its per-state cycle counter and the Moore output decode.
module npu_seq_ctrl
  import npu_ctrl_pkg::*;
#(
  parameter int                    DWidth     = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    ARRAY_M    = 16,
  parameter int                    ARRAY_N    = 16,
  parameter int                    K_MAX      = 256,
  parameter logic [ADDR_WIDTH-1:0] PARA_BASE  = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        cen_i,
  input  logic                        wen_i,
  input  logic [ADDR_WIDTH-1:0]       addr_i,
  input  logic [DWidth-1:0]           wdata_i,
  output logic [DWidth-1:0]           rdata_o,
  output logic                        a_buf_on_o,
  output logic                        w_buf_on_o,
  output logic [ADDR_WIDTH-1:0]       a_base_addr_o,
  output logic [ADDR_WIDTH-1:0]       w_base_addr_o,
  output logic [ADDR_WIDTH-1:0]       o_base_addr_o,
  output logic [$clog2(ARRAY_M):0]    a_num_rows_o,
  output logic [$clog2(ARRAY_N):0]    w_num_cols_o,
  output logic                        mode_o,
  output logic [2:0]                  op_sig_o,
  output logic                        o_ag_on_o,
  output logic                        sa_rst_o,
  output logic                        intra_on_o,
  output logic                        intra_start_o,
  output logic [ADDR_WIDTH-1:0]       intra_o_base_o,
  output logic [ADDR_WIDTH-1:0]       intra_a_base_o,
  output logic                        irq_o
);

  localparam int MW = $clog2(ARRAY_M) + 1;
  localparam int NW = $clog2(ARRAY_N) + 1;
  localparam int KW = $clog2(K_MAX) + 1;
  localparam int CW = $clog2(K_MAX + ARRAY_M + ARRAY_N) + 1;

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          abort_rst_q, abort_rst_d;
  logic          busy, set_done, os_go, intra_go, abort, irq_en, done;
  logic [MW-1:0] m;
  logic [NW-1:0] n;
  logic [KW-1:0] k;
  logic [CW-1:0] last_f1, last_f2, last_dr, last_st, last_ir;
  logic          skip_drain;

  assign busy = (state_q != IDLE);

  npu_ctrl_regfile #(
    .DWidth    (DWidth),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ARRAY_M   (ARRAY_M),
    .ARRAY_N   (ARRAY_N),
    .K_MAX     (K_MAX),
    .PARA_BASE (PARA_BASE)
  ) u_regfile (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .cen_i         (cen_i),
    .wen_i         (wen_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .rdata_o       (rdata_o),
    .busy_i        (busy),
    .set_done_i    (set_done),
    .os_go_o       (os_go),
    .intra_go_o    (intra_go),
    .abort_o       (abort),
    .irq_en_o      (irq_en),
    .done_o        (done),
    .a_base_o      (a_base_addr_o),
    .w_base_o      (w_base_addr_o),
    .o_base_o      (o_base_addr_o),
    .intra_o_base_o(intra_o_base_o),
    .intra_a_base_o(intra_a_base_o),
    .m_o           (m),
    .n_o           (n),
    .k_o           (k)
  );

  assign a_num_rows_o = m;
  assign w_num_cols_o = n;
  assign mode_o       = 1'b1;
  assign irq_o        = done && irq_en;

  // Terminal count per state is (length - 1); M,N,K are nonzero once running
  assign last_f1    = CW'(k) - CW'(1);
  assign last_f2    = CW'(m) + CW'(n) - CW'(2);
  assign last_dr    = CW'(ARRAY_N) - CW'(m) - CW'(1);
  assign last_st    = CW'(m);
  assign last_ir    = CW'(m) + CW'(ARRAY_N) - CW'(2);
  assign skip_drain = (CW'(m) >= CW'(ARRAY_N));

  // State, counter and abort-clear pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      abort_rst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      abort_rst_q <= abort_rst_d;
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CW'(1);
    abort_rst_d   = 1'b0;
    set_done      = 1'b0;
    a_buf_on_o    = 1'b0;
    w_buf_on_o    = 1'b0;
    op_sig_o      = OP_IDLE;
    o_ag_on_o     = 1'b0;
    sa_rst_o      = abort_rst_q;
    intra_on_o    = 1'b0;
    intra_start_o = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (os_go)         state_d = OS_FLOW1;
        else if (intra_go) state_d = INTRA_RUN;
      end
      OS_FLOW1: begin
        a_buf_on_o = 1'b1;
        w_buf_on_o = 1'b1;
        op_sig_o   = OP_FLOW;
        if (cnt_q == last_f1) state_d = OS_FLOW2;
      end
      OS_FLOW2: begin
        op_sig_o = OP_FLOW;
        if (cnt_q == last_f2) state_d = skip_drain ? OS_STORE : OS_DRAIN;
      end
      OS_DRAIN: begin
        op_sig_o = OP_DRAIN;
        if (cnt_q == last_dr) state_d = OS_STORE;
      end
      OS_STORE: begin
        o_ag_on_o = 1'b1;
        if (cnt_q == last_st) state_d = OS_END;
      end
      OS_END: begin
        if (cnt_q == '0) sa_rst_o = 1'b1;
        if (cnt_q == CW'(3)) begin
          state_d  = IDLE;
          set_done = 1'b1;
        end
      end
      INTRA_RUN: begin
        intra_on_o = 1'b1;
        if (cnt_q == '0) intra_start_o = 1'b1;
        if (cnt_q == last_ir) state_d = INTRA_END;
      end
      INTRA_END: begin
        state_d  = IDLE;
        set_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides any pending transition, including a normal exit
    if (busy && abort) begin
      state_d     = IDLE;
      set_done    = 1'b0;
      abort_rst_d = 1'b1;
    end
    if (state_d != state_q) cnt_d = '0;
  end

endmodule
